// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw levels and repeat enables in, debounced level and
// press/release event pulses out.
interface button_debouncer_if #(
    parameter int unsigned CHANNELS = 5
);
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;

    modport master (
        output raw_in,
        output repeat_en,
        input  level_out,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  raw_in,
        input  repeat_en,
        output level_out,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel debounce FSM with
// auto-repeat, and registered level/press/release outputs.
module button_debouncer #(
    parameter int unsigned CHANNELS        = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 50_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input logic               clk,
    input logic               rst,
    button_debouncer_if.slave btn
);

    localparam int unsigned MaxAb  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY;
    localparam int unsigned MaxCnt = (MaxAb > REPEAT_PERIOD) ? MaxAb : REPEAT_PERIOD;
    // Counter only ever holds values up to MaxCnt-1.
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] DlyLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] PerLast = CntW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StHeld,
        StRepeat,
        StReleaseWait
    } state_e;

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn.raw_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e          r_state;
        state_e          w_state_d;
        logic [CntW-1:0] r_cnt;
        logic [CntW-1:0] w_cnt_d;
        logic            w_press_d;
        logic            w_release_d;
        logic            w_level_d;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            w_sync;

        assign w_sync = r_sync2[g];

        always_comb begin
            w_state_d   = r_state;
            w_cnt_d     = r_cnt + 1'b1;
            w_press_d   = 1'b0;
            w_release_d = 1'b0;
            unique case (r_state)
                StIdle: begin
                    w_cnt_d = '0;
                    if (w_sync) begin
                        w_state_d = StPressWait;
                    end
                end
                StPressWait: begin
                    if (!w_sync) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end else if (r_cnt == DebLast) begin
                        w_state_d = StHeld;
                        w_cnt_d   = '0;
                        w_press_d = 1'b1;
                    end
                end
                StHeld: begin
                    if (!w_sync) begin
                        w_state_d = StReleaseWait;
                        w_cnt_d   = '0;
                    end else if (!btn.repeat_en[g]) begin
                        w_cnt_d = '0;
                    end else if (r_cnt == DlyLast) begin
                        w_state_d = StRepeat;
                        w_cnt_d   = '0;
                        w_press_d = 1'b1;
                    end
                end
                StRepeat: begin
                    if (!w_sync) begin
                        w_state_d = StReleaseWait;
                        w_cnt_d   = '0;
                    end else if (!btn.repeat_en[g]) begin
                        w_state_d = StHeld;
                        w_cnt_d   = '0;
                    end else if (r_cnt == PerLast) begin
                        w_cnt_d   = '0;
                        w_press_d = 1'b1;
                    end
                end
                StReleaseWait: begin
                    // A return to high is a bounce; going back to HELD restarts repeat timing.
                    if (w_sync) begin
                        w_state_d = StHeld;
                        w_cnt_d   = '0;
                    end else if (r_cnt == DebLast) begin
                        w_state_d   = StIdle;
                        w_cnt_d     = '0;
                        w_release_d = 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
            w_level_d = (w_state_d == StHeld) || (w_state_d == StRepeat) ||
                        (w_state_d == StReleaseWait);
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state   <= StIdle;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_d;
                r_cnt     <= w_cnt_d;
                r_level   <= w_level_d;
                r_press   <= w_press_d;
                r_release <= w_release_d;
            end
        end

        assign btn.level_out[g]     = r_level;
        assign btn.press_pulse[g]   = r_press;
        assign btn.release_pulse[g] = r_release;
    end

endmodule
